// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame engine.
//   mode_e       : pattern select encoding (image, bars, checkerboard, grey)
//   rgb_t        : per-channel on/off flags, expanded to full width by the engine
//   Bar*         : the eight colour-bar colours, left to right
//   Def*         : 640x480@60 timing defaults
package vga_pkg;

  typedef enum logic [1:0] {
    ModeImage   = 2'd0,
    ModeBars    = 2'd1,
    ModeChecker = 2'd2,
    ModeGrey    = 2'd3
  } mode_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t BarWhite   = rgb_t'(3'b111);
  localparam rgb_t BarYellow  = rgb_t'(3'b110);
  localparam rgb_t BarCyan    = rgb_t'(3'b011);
  localparam rgb_t BarGreen   = rgb_t'(3'b010);
  localparam rgb_t BarMagenta = rgb_t'(3'b101);
  localparam rgb_t BarRed     = rgb_t'(3'b100);
  localparam rgb_t BarBlue    = rgb_t'(3'b001);
  localparam rgb_t BarBlack   = rgb_t'(3'b000);

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BarWhite;
      3'd1:    return BarYellow;
      3'd2:    return BarCyan;
      3'd3:    return BarGreen;
      3'd4:    return BarMagenta;
      3'd5:    return BarRed;
      3'd6:    return BarBlue;
      default: return BarBlack;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters with raw (undelayed) sync and visible flags.
//   clk, reset         : pixel clock, synchronous active-high reset
//   h, v               : current raster position
//   hsync_act/vsync_act: high while inside the sync pulse (polarity applied later)
//   visible            : high inside the active picture
module vga_timing_counter import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hsync_act,
  output logic          vsync_act,
  output logic          visible
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic [31:0]   h32, v32;

  // Compare at 32 bits so totals that are exact powers of two cannot alias.
  assign h32 = 32'(h_q);
  assign v32 = 32'(v_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h32 == HTotal - 1) begin
      h_q <= '0;
      v_q <= (v32 == VTotal - 1) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign hsync_act = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
  assign vsync_act = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);
  assign visible   = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);

endmodule

// File: rtl/vga_frame_engine.sv
// VGA frame engine: raster timing, ROM image fetch with pixel replication, test patterns.
//   clk, reset          : pixel clock, synchronous active-high reset
//   mode                : pattern select, sampled at raster (0,0)
//   rom_addr / rom_data : greyscale image ROM, data valid ROM_LAT cycles after address
//   vga_r/g/b           : colour channels, zero outside the visible area
//   hsync, vsync        : sync outputs, asserted level SYNC_POL
//   frame_start         : one-cycle pulse alongside pixel (0,0)
// All outputs trail the raster counters by 1+ROM_LAT cycles.
module vga_frame_engine import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned IMG_W    = 160,
  parameter int unsigned IMG_H    = 120,
  parameter int unsigned SCALE    = 4,
  parameter int unsigned PIX_W    = 4,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       mode,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   rom_addr,
  input  logic [PIX_W-1:0]                 rom_data,
  output logic [PIX_W-1:0]                 vga_r,
  output logic [PIX_W-1:0]                 vga_g,
  output logic [PIX_W-1:0]                 vga_b,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             frame_start
);

  localparam int unsigned AW      = $clog2(IMG_W * IMG_H);
  localparam int unsigned HW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned ScaleSh = $clog2(SCALE);
  localparam int unsigned BarW    = H_ACTIVE / 8;
  localparam logic        SyncPol = (SYNC_POL != 0);

  if (!(SCALE == 1 || SCALE == 2 || SCALE == 4 || SCALE == 8)) begin : g_bad_scale
    $error("SCALE must be 1, 2, 4 or 8");
  end
  if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
    $error("ROM_LAT must be in 1..3");
  end
  if (IMG_W * SCALE > H_ACTIVE || IMG_H * SCALE > V_ACTIVE) begin : g_bad_img
    $error("scaled image does not fit the active area");
  end
  if (H_ACTIVE % 8 != 0) begin : g_bad_hactive
    $error("H_ACTIVE must be a multiple of 8");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hsync_act, vsync_act, visible;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .h         (h),
    .v         (v),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .visible   (visible)
  );

  logic [31:0] h32, v32;
  logic        first_px, in_img;
  mode_e       mode_q, mode_eff;

  assign h32      = 32'(h);
  assign v32      = 32'(v);
  assign first_px = (h32 == 0) && (v32 == 0);
  assign in_img   = (h32 < IMG_W * SCALE) && (v32 < IMG_H * SCALE);
  // Pixel (0,0) already uses the mode being sampled, so a frame never mixes modes.
  assign mode_eff = first_px ? mode_e'(mode) : mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= ModeImage;
    end else if (first_px) begin
      mode_q <= mode_e'(mode);
    end
  end

  // Stage-1 pattern generation; image pixels are filled in from rom_data at the output.
  logic [3*PIX_W-1:0] pat_d;
  logic [PIX_W-1:0]   grey;
  logic               use_rom_d;
  rgb_t               bar;

  always_comb begin
    pat_d     = '0;
    use_rom_d = 1'b0;
    bar       = BarBlack;
    grey      = '0;
    grey[PIX_W-1] = 1'b1;
    case (mode_eff)
      ModeImage: use_rom_d = in_img;
      ModeBars: begin
        bar   = bar_colour(3'(h32 / BarW));
        pat_d = {{PIX_W{bar.r}}, {PIX_W{bar.g}}, {PIX_W{bar.b}}};
      end
      ModeChecker: pat_d = {(3 * PIX_W){~(h32[5] ^ v32[5])}};
      ModeGrey:    pat_d = {3{grey}};
      default:     pat_d = '0;
    endcase
  end

  // Index 0 is loaded alongside rom_addr; index ROM_LAT lines up with rom_data.
  logic [ROM_LAT:0]   vis_p, rom_p, hs_p, vs_p, fs_p;
  logic [3*PIX_W-1:0] pat_p [ROM_LAT+1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      vis_p    <= '0;
      rom_p    <= '0;
      hs_p     <= '0;
      vs_p     <= '0;
      fs_p     <= '0;
      for (int i = 0; i <= int'(ROM_LAT); i++) pat_p[i] <= '0;
    end else begin
      rom_addr <= in_img ? AW'((v32 >> ScaleSh) * IMG_W + (h32 >> ScaleSh)) : '0;
      vis_p    <= {vis_p[ROM_LAT-1:0], visible};
      rom_p    <= {rom_p[ROM_LAT-1:0], use_rom_d};
      hs_p     <= {hs_p[ROM_LAT-1:0], hsync_act};
      vs_p     <= {vs_p[ROM_LAT-1:0], vsync_act};
      fs_p     <= {fs_p[ROM_LAT-1:0], first_px};
      pat_p[0] <= pat_d;
      for (int i = 1; i <= int'(ROM_LAT); i++) pat_p[i] <= pat_p[i-1];
    end
  end

  always_comb begin
    {vga_r, vga_g, vga_b} = '0;
    if (vis_p[ROM_LAT]) begin
      if (rom_p[ROM_LAT]) begin
        {vga_r, vga_g, vga_b} = {3{rom_data}};
      end else begin
        {vga_r, vga_g, vga_b} = pat_p[ROM_LAT];
      end
    end
  end

  assign hsync       = hs_p[ROM_LAT] ? SyncPol : ~SyncPol;
  assign vsync       = vs_p[ROM_LAT] ? SyncPol : ~SyncPol;
  assign frame_start = fs_p[ROM_LAT];

endmodule

// File: tb/tb_vga_frame_engine.sv
// Scoreboard bench. Instance A: reduced 14x9 raster, 4x3 image at SCALE 2, ROM_LAT 2.
// Instance B: 640-wide line, 5-line frame, 4x1 image, ROM_LAT 1, mode switching.
// Expected samples are queued against a free-running cycle count; the monitor compares them.
module tb_vga_frame_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [1:0] mode_a, mode_b;
  logic [3:0] rom_addr_a, rom_data_a, r_a, g_a, b_a;
  logic [1:0] rom_addr_b;
  logic [3:0] rom_data_b, r_b, g_b, b_b;
  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  vga_frame_engine #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .IMG_W (4), .IMG_H (3), .SCALE (2), .PIX_W (4), .ROM_LAT (2), .SYNC_POL (0)
  ) u_dut_a (
    .clk (clk), .reset (reset_a), .mode (mode_a),
    .rom_addr (rom_addr_a), .rom_data (rom_data_a),
    .vga_r (r_a), .vga_g (g_a), .vga_b (b_a),
    .hsync (hs_a), .vsync (vs_a), .frame_start (fs_a)
  );

  vga_frame_engine #(
    .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .IMG_W (4), .IMG_H (1), .SCALE (1), .PIX_W (4), .ROM_LAT (1), .SYNC_POL (0)
  ) u_dut_b (
    .clk (clk), .reset (reset_b), .mode (mode_b),
    .rom_addr (rom_addr_b), .rom_data (rom_data_b),
    .vga_r (r_b), .vga_g (g_b), .vga_b (b_b),
    .hsync (hs_b), .vsync (vs_b), .frame_start (fs_b)
  );

  // ROM models: content equals address.
  logic [3:0] rom_pipe_a [2];
  logic [3:0] rom_q_b;
  always @(posedge clk) begin
    rom_pipe_a[0] <= rom_addr_a;
    rom_pipe_a[1] <= rom_pipe_a[0];
    rom_q_b       <= {2'b00, rom_addr_b};
  end
  assign rom_data_a = rom_pipe_a[1];
  assign rom_data_b = rom_q_b;

  int unsigned gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  typedef struct {
    int unsigned cyc;
    int          dut;
    int          sig;
    int          exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;

  // sig: 0 r, 1 g, 2 b, 3 hsync, 4 vsync, 5 frame_start, 6 rom_addr, 7..9 running counts (A)
  function automatic string sig_name(input int sig);
    case (sig)
      0: return "vga_r";
      1: return "vga_g";
      2: return "vga_b";
      3: return "hsync";
      4: return "vsync";
      5: return "frame_start";
      6: return "rom_addr";
      7: return "hsync_low_count";
      8: return "vsync_low_count";
      default: return "frame_start_count";
    endcase
  endfunction

  function automatic int obs(input int dut, input int sig);
    if (dut == 0) begin
      case (sig)
        0: return int'(r_a);
        1: return int'(g_a);
        2: return int'(b_a);
        3: return int'(hs_a);
        4: return int'(vs_a);
        5: return int'(fs_a);
        6: return int'(rom_addr_a);
        7: return hs_cnt;
        8: return vs_cnt;
        default: return fs_cnt;
      endcase
    end
    case (sig)
      0: return int'(r_b);
      1: return int'(g_b);
      2: return int'(b_b);
      3: return int'(hs_b);
      4: return int'(vs_b);
      5: return int'(fs_b);
      default: return int'(rom_addr_b);
    endcase
  endfunction

  task automatic push(input int unsigned cyc, input int dut, input int sig, input int exp);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.sig = sig; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic push_rgb(input int unsigned cyc, input int dut, input int r, input int g,
                          input int b);
    push(cyc, dut, 0, r);
    push(cyc, dut, 1, g);
    push(cyc, dut, 2, b);
  endtask

  // Monitor: sample on the falling edge, update running counts, then retire due entries.
  always @(negedge clk) begin
    if (reset_a) begin
      hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    end else begin
      if (!hs_a) hs_cnt++;
      if (!vs_a) vs_cnt++;
      if (fs_a)  fs_cnt++;
    end
    while (q.size() > 0 && q[0].cyc <= gcyc) begin
      exp_t e;
      int   got;
      e = q.pop_front();
      checks++;
      got = obs(e.dut, e.sig);
      if (e.cyc != gcyc) begin
        errors++;
        $display("FAIL %s dut%0d: sample for cycle %0d missed (now %0d)", sig_name(e.sig),
                 e.dut, e.cyc, gcyc);
      end else if (got != e.exp) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", sig_name(e.sig), e.dut,
                 e.cyc, got, e.exp);
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: time limit reached with %0d samples pending", q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int unsigned base;

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    mode_a  = 2'd0; mode_b  = 2'd1;

    // ---- Instance A: output at cycle c shows pixel c-3 (h = p%14, v = p/14)
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0;
    base = gcyc;
    push(base, 0, 3, 1); push(base, 0, 4, 1); push(base, 0, 5, 0); push(base, 0, 0, 0);
    push(base, 0, 6, 0);
    push(base + 2, 0, 5, 0);
    push(base + 3, 0, 5, 1); push(base + 3, 0, 0, 0);
    push(base + 5, 0, 0, 1);
    push(base + 16, 0, 7, 2);
    push(base + 48, 0, 6, 6);
    push_rgb(base + 50, 0, 6, 6, 6); push(base + 50, 0, 3, 1);
    push(base + 52, 0, 0, 7);
    push(base + 53, 0, 0, 0);
    push(base + 55, 0, 3, 0);
    push(base + 56, 0, 3, 0);
    push(base + 57, 0, 3, 1);
    push(base + 80, 0, 0, 11);
    push(base + 87, 0, 0, 0);
    push(base + 100, 0, 4, 1);
    push(base + 101, 0, 4, 0);
    push(base + 114, 0, 4, 0);
    push(base + 115, 0, 4, 1);
    push(base + 128, 0, 7, 18); push(base + 128, 0, 8, 14); push(base + 128, 0, 9, 1);
    push(base + 128, 0, 5, 0);
    push(base + 129, 0, 5, 1);
    push(base + 190, 0, 0, 10); push(base + 190, 0, 6, 11);
    push_rgb(base + 191, 0, 0, 0, 0); push(base + 191, 0, 6, 0);
    push(base + 191, 0, 3, 1); push(base + 191, 0, 4, 1); push(base + 191, 0, 5, 0);

    // Mid-frame reset, held for 3 cycles
    repeat (190) @(posedge clk);
    #1 reset_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0;
    base = gcyc;
    push(base + 2, 0, 5, 0); push(base + 2, 0, 3, 1);
    push(base + 3, 0, 5, 1);
    push(base + 50, 0, 0, 6);

    // ---- Instance B: output at cycle c shows pixel c-2 (h = p%800, v = p/800)
    repeat (60) @(posedge clk);
    #1 reset_b = 1'b0;
    base = gcyc;
    push(base + 2, 1, 5, 1); push_rgb(base + 2, 1, 15, 15, 15);
    push_rgb(base + 81, 1, 15, 15, 15);
    push_rgb(base + 82, 1, 15, 15, 0);
    push_rgb(base + 242, 1, 0, 15, 0);
    push_rgb(base + 322, 1, 15, 0, 15);
    push_rgb(base + 402, 1, 15, 0, 0);
    push_rgb(base + 482, 1, 0, 0, 15);
    push_rgb(base + 562, 1, 0, 0, 0);
    push(base + 657, 1, 3, 1);
    push(base + 658, 1, 3, 0);
    push_rgb(base + 1042, 1, 0, 15, 0);
    push(base + 4002, 1, 5, 1); push(base + 4002, 1, 0, 0);
    push(base + 4004, 1, 0, 2); push(base + 4004, 1, 6, 3);
    push(base + 4005, 1, 0, 3);
    push(base + 4006, 1, 0, 0);
    push(base + 4866, 1, 0, 0);
    push(base + 8002, 1, 5, 1); push(base + 8002, 1, 0, 15);
    push(base + 8034, 1, 0, 0);
    push_rgb(base + 8066, 1, 15, 15, 15);

    repeat (1000) @(posedge clk);
    #1 mode_b = 2'd0;
    repeat (3810) @(posedge clk);
    #1 mode_b = 2'd2;
    repeat (3270) @(posedge clk);

    repeat (5) @(negedge clk);
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: %0d expected samples never compared", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
